// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tone_pkg
// Brief    : Shared state encoding, width defaults and helpers for tone_arbiter.
// Revision : 1.0
// ============================================================================
package tone_pkg;

    localparam int FREQ_W_DEF = 32;
    localparam int DUR_W_DEF  = 32;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_GAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        PLAY = ST_PLAY,
        GAP  = ST_GAP
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin winner select with optional slot-0 priority.
// Revision : 1.0
// ============================================================================
module rr_picker
    import tone_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               prio0,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    int idx;

    // Scan from farthest to nearest so the nearest valid slot after last_grant wins.
    always_comb begin
        winner    = '0;
        idx       = 0;
        any_valid = |req;
        if (!(prio0 && req[0])) begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                idx = int'(last_grant) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (req[ID_W'(idx)]) begin
                    winner = ID_W'(idx);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tone_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tone_arbiter
// Brief    : Shares one tone generator between NUM_REQ note sources.
// Revision : 1.0
// ============================================================================
module tone_arbiter
    import tone_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int PREEMPT  = 0,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FREQ_W-1:0] req_freq,
    input  logic [NUM_REQ*DUR_W-1:0]  req_dur,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_abort,
    input  logic                      stop,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [FREQ_W-1:0]         tone_freq,
    output logic [DUR_W-1:0]          tone_dur,
    output logic                      tone_enable,
    input  logic                      tone_done
);

    localparam logic c_prio0 = (PREEMPT != 0);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [FREQ_W-1:0]   tone_freq_q, tone_freq_d;
    logic [DUR_W-1:0]    tone_dur_q, tone_dur_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  abort_q, abort_d;

    logic [FREQ_W-1:0]   w_slot_freq [NUM_REQ];
    logic [DUR_W-1:0]    w_slot_dur  [NUM_REQ];
    logic [ID_W-1:0]     w_winner;
    logic                w_any;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign w_slot_freq[i] = req_freq[i*FREQ_W +: FREQ_W];
        assign w_slot_dur[i]  = req_dur[i*DUR_W +: DUR_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .prio0      (c_prio0),
        .winner     (w_winner),
        .any_valid  (w_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tone_freq_d  = tone_freq_q;
        tone_dur_d   = tone_dur_q;
        done_d       = '0;
        abort_d      = '0;
        req_ready    = '0;
        tone_enable  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop && w_any) begin
                    req_ready[w_winner] = 1'b1;
                    grant_id_d          = w_winner;
                    last_grant_d        = w_winner;
                    tone_freq_d         = w_slot_freq[w_winner];
                    tone_dur_d          = w_slot_dur[w_winner];
                    // A zero-length note never reaches the generator.
                    if (w_slot_dur[w_winner] == '0) begin
                        done_d[w_winner] = 1'b1;
                        state_d          = GAP;
                    end else begin
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                tone_enable = !stop;
                if (!stop) begin
                    if (tone_done) begin
                        done_d[grant_id_q] = 1'b1;
                        state_d            = GAP;
                    end else if (c_prio0 && req_valid[0] && (grant_id_q != '0)) begin
                        abort_d[grant_id_q] = 1'b1;
                        state_d             = GAP;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tone_freq_q  <= '0;
            tone_dur_q   <= '0;
            done_q       <= '0;
            abort_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tone_freq_q  <= tone_freq_d;
            tone_dur_q   <= tone_dur_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

    assign req_done  = done_q;
    assign req_abort = abort_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_id_q;
    assign tone_freq = tone_freq_q;
    assign tone_dur  = tone_dur_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_arbiter
// Brief    : Scoreboard bench for tone_arbiter, one instance without and one with preemption.
// Revision : 1.0
// ============================================================================
module tb_tone_arbiter;

    localparam int NR = 3;
    localparam int GW = 2;
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_GAP  = 2;

    typedef struct {
        int            cyc;
        logic [NR-1:0] rdy;
        logic [NR-1:0] dn;
        logic [NR-1:0] ab;
        logic          busy;
        logic          en;
        logic [GW-1:0] gid;
        logic [31:0]   f;
        logic [31:0]   d;
    } rec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              stop;
    logic [NR-1:0]     req_valid;
    logic [NR*32-1:0]  req_freq;
    logic [NR*32-1:0]  req_dur;
    logic              done_man;
    logic              gen_auto;
    logic              keep_valid;
    logic              tone_done;
    logic [31:0]       gen_cnt = 32'd0;

    logic [1:0][NR-1:0] rdy, dn, ab;
    logic [1:0]         busy, en;
    logic [1:0][GW-1:0] gid;
    logic [1:0][31:0]   tf, td;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    rec_t q0[$];
    rec_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator stand-in: finishes after tone_dur enabled cycles, restarts when enable drops.
    assign tone_done = done_man | (gen_auto & en[0] & (gen_cnt == td[0] - 32'd1));
    always @(posedge clk) gen_cnt <= en[0] ? gen_cnt + 32'd1 : 32'd0;

    function automatic logic [GW-1:0] pick(input bit pre, input int lst, input logic [NR-1:0] v);
        logic [NR-1:0] sh;
        if (pre && v[0]) return '0;
        for (int k = 1; k <= NR; k++) begin
            sh = v >> ((lst + k) % NR);
            if (sh[0]) return GW'((lst + k) % NR);
        end
        return '0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit PRE = (g == 1);

        tone_arbiter #(
            .NUM_REQ (NR),
            .FREQ_W  (32),
            .DUR_W   (32),
            .PREEMPT (g)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid),
            .req_freq    (req_freq),
            .req_dur     (req_dur),
            .req_ready   (rdy[g]),
            .req_done    (dn[g]),
            .req_abort   (ab[g]),
            .stop        (stop),
            .busy        (busy[g]),
            .grant_id    (gid[g]),
            .tone_freq   (tf[g]),
            .tone_dur    (td[g]),
            .tone_enable (en[g]),
            .tone_done   (tone_done)
        );

        int            mode = M_IDLE;
        logic [GW-1:0] last, gidm;
        logic [31:0]   cf, cd;
        logic [NR-1:0] dpend = '0, apend = '0, acc = '0;
        bit            live = 1'b0;

        // Reference: expected outputs for this cycle, then the owner/mode after the edge.
        always @(negedge clk) begin : p_model
            rec_t          r;
            logic [GW-1:0] w;
            logic [NR-1:0] nd, na;
            logic [31:0]   dw;
            bit            was;
            was    = live;
            r.cyc  = cyc;
            r.rdy  = '0;
            r.dn   = dpend;
            r.ab   = apend;
            r.busy = (mode != M_IDLE);
            r.en   = (mode == M_PLAY) && !stop;
            r.gid  = gidm;
            r.f    = cf;
            r.d    = cd;
            nd     = '0;
            na     = '0;
            acc    = '0;
            if (reset) begin
                mode = M_IDLE;
                last = GW'(NR - 1);
                gidm = '0;
                cf   = '0;
                cd   = '0;
                live = 1'b1;
            end else if (live) begin
                if (mode == M_IDLE) begin
                    if (!stop && req_valid != '0) begin
                        w        = pick(PRE, int'(last), req_valid);
                        r.rdy[w] = 1'b1;
                        acc[w]   = 1'b1;
                        gidm     = w;
                        last     = w;
                        cf       = 32'(req_freq >> (int'(w) * 32));
                        dw       = 32'(req_dur >> (int'(w) * 32));
                        cd       = dw;
                        if (dw == 32'd0) begin
                            nd[w] = 1'b1;
                            mode  = M_GAP;
                        end else begin
                            mode = M_PLAY;
                        end
                    end
                end else if (mode == M_PLAY) begin
                    if (!stop && tone_done) begin
                        nd[gidm] = 1'b1;
                        mode     = M_GAP;
                    end else if (PRE && !stop && req_valid[0] && gidm != '0) begin
                        na[gidm] = 1'b1;
                        mode     = M_GAP;
                    end
                end else begin
                    mode = M_IDLE;
                end
            end
            dpend = nd;
            apend = na;
            if (was) begin
                if (g == 0) q0.push_back(r);
                else        q1.push_back(r);
            end
        end
    end

    task automatic cmp(input string nm, input int inst, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, inst, c, act, exp);
        end
    endtask

    task automatic check_rec(input int inst, input rec_t e, input logic [NR-1:0] a_rdy,
                             input logic [NR-1:0] a_dn, input logic [NR-1:0] a_ab, input logic a_busy,
                             input logic a_en, input logic [GW-1:0] a_gid, input logic [31:0] a_f,
                             input logic [31:0] a_d);
        cmp("req_ready",   inst, e.cyc, 64'(a_rdy),  64'(e.rdy));
        cmp("req_done",    inst, e.cyc, 64'(a_dn),   64'(e.dn));
        cmp("req_abort",   inst, e.cyc, 64'(a_ab),   64'(e.ab));
        cmp("busy",        inst, e.cyc, 64'(a_busy), 64'(e.busy));
        cmp("tone_enable", inst, e.cyc, 64'(a_en),   64'(e.en));
        cmp("grant_id",    inst, e.cyc, 64'(a_gid),  64'(e.gid));
        cmp("tone_freq",   inst, e.cyc, 64'(a_f),    64'(e.f));
        cmp("tone_dur",    inst, e.cyc, 64'(a_d),    64'(e.d));
    endtask

    always @(negedge clk) begin : p_mon
        rec_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_rec(0, e, rdy[0], dn[0], ab[0], busy[0], en[0], gid[0], tf[0], td[0]);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_rec(1, e, rdy[1], dn[1], ab[1], busy[1], en[1], gid[1], tf[1], td[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (!keep_valid) req_valid = req_valid & ~g_dut[0].acc;
    endtask

    task automatic set_note(input int i, input logic [31:0] f, input logic [31:0] d);
        logic [NR*32-1:0] msk;
        msk       = (NR*32)'(32'hFFFF_FFFF) << (i * 32);
        req_freq  = (req_freq & ~msk) | ((NR*32)'(f) << (i * 32));
        req_dur   = (req_dur & ~msk) | ((NR*32)'(d) << (i * 32));
        req_valid = req_valid | (NR'(1) << i);
    endtask

    task automatic drain();
        req_valid = '0;
        done_man  = 1'b1;
        repeat (3) step();
        done_man = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        logic [NR-1:0] sh;
        reset      = 1'b1;
        stop       = 1'b0;
        req_valid  = '0;
        req_freq   = '0;
        req_dur    = '0;
        done_man   = 1'b0;
        gen_auto   = 1'b0;
        keep_valid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // Single requester, generator done after 20 cycles
        set_note(1, 32'd440, 32'd150);
        repeat (20) step();
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        repeat (4) step();

        // Round robin, every requester always valid, 5-cycle notes
        keep_valid = 1'b1;
        gen_auto   = 1'b1;
        set_note(0, 32'd100, 32'd5);
        set_note(1, 32'd200, 32'd5);
        set_note(2, 32'd300, 32'd5);
        repeat (45) step();
        keep_valid = 1'b0;
        req_valid  = '0;
        repeat (10) step();
        gen_auto = 1'b0;
        drain();

        // Zero duration
        set_note(2, 32'd1000, 32'd0);
        repeat (4) step();

        // Pause with a generator done during the stop
        set_note(0, 32'd500, 32'd100);
        repeat (5) step();
        stop = 1'b1;
        repeat (3) step();
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        repeat (6) step();
        stop = 1'b0;
        repeat (4) step();
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        repeat (3) step();
        drain();

        // Requester 0 arrives while 2 plays; then the same with a simultaneous done
        set_note(2, 32'd300, 32'd100);
        repeat (4) step();
        set_note(0, 32'd600, 32'd3);
        repeat (6) step();
        drain();
        set_note(2, 32'd0, 32'd100);
        repeat (4) step();
        set_note(0, 32'd700, 32'd100);
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        repeat (3) step();
        drain();

        // Reset in the middle of a note; first grant afterwards goes to 0
        set_note(1, 32'd800, 32'd100);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_note(2, 32'd900, 32'd4);
        set_note(0, 32'd950, 32'd4);
        repeat (3) step();
        drain();

        // Randomized traffic
        gen_auto = 1'b1;
        repeat (3000) begin
            for (int i = 0; i < NR; i++) begin
                sh = req_valid >> i;
                if (!sh[0]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_note(i, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom),
                                 32'($urandom_range(0, 6)));
                end else if ($urandom_range(0, 29) == 0) begin
                    req_valid = req_valid & ~(NR'(1) << i);
                end
            end
            stop     = ($urandom_range(0, 11) == 0);
            done_man = ($urandom_range(0, 15) == 0);
            step();
        end
        stop     = 1'b0;
        gen_auto = 1'b0;
        drain();
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
